// File: rtl/car_sensor_conditioner_pkg.sv
// Shared lane-state encodings and default timing for the two-lane loop-sensor front end.
// Optional per-lane car counters are built when CAR_COUNT_EN is defined.
package car_sensor_conditioner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_PRESENT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_FAULT   = 3'd4
    } lane_state_e;

    localparam int unsigned DEF_DEB_CYCLES   = 4;
    localparam int unsigned DEF_HOLD_CYCLES  = 8;
    localparam int unsigned DEF_STUCK_CYCLES = 255;
    localparam int unsigned DEF_CNT_W        = 8;

endpackage

// File: rtl/car_sensor_channel.sv
// One lane: 2-flop synchroniser, debounce/hold/stuck-detect FSM, optional saturating car counter.
// Counter logic and its ports exist only when CAR_COUNT_EN is defined.
module car_sensor_channel
    import car_sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int unsigned STUCK_CYCLES = DEF_STUCK_CYCLES
`ifdef CAR_COUNT_EN
    ,
    parameter int unsigned CNT_W        = DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw,
    output logic             car,
    output logic             fault
`ifdef CAR_COUNT_EN
    ,
    input  logic             count_clr,
    output logic [CNT_W-1:0] count
`endif
);

    localparam int unsigned DCW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int unsigned SCW = (STUCK_CYCLES > 2) ? $clog2(STUCK_CYCLES) : 1;

    logic [1:0]     sync_q;
    logic           s;
    lane_state_e    state, state_n;
    logic [DCW-1:0] dcnt, dcnt_n;
    logic [HCW-1:0] hcnt, hcnt_n;
    logic [SCW-1:0] scnt, scnt_n;

    assign s = sync_q[1];

    // State, counters and outputs; car/fault are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            state  <= ST_IDLE;
            dcnt   <= '0;
            hcnt   <= '0;
            scnt   <= '0;
            car    <= 1'b0;
            fault  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            state  <= state_n;
            dcnt   <= dcnt_n;
            hcnt   <= hcnt_n;
            scnt   <= scnt_n;
            car    <= (state_n == ST_PRESENT) || (state_n == ST_HOLD);
            fault  <= (state_n == ST_FAULT);
        end
    end

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        hcnt_n  = hcnt;
        scnt_n  = scnt;
        case (state)
            ST_IDLE: begin
                if (s) begin
                    state_n = ST_ARM;
                    dcnt_n  = DCW'(1);
                end
            end
            ST_ARM: begin
                if (!s) begin
                    state_n = ST_IDLE;
                end else if (dcnt == DCW'(DEB_CYCLES - 1)) begin
                    state_n = ST_PRESENT;
                    scnt_n  = '0;
                end else begin
                    dcnt_n = dcnt + DCW'(1);
                end
            end
            ST_PRESENT: begin
                if (!s) begin
                    state_n = ST_HOLD;
                    hcnt_n  = HCW'(1);
                end else if (scnt == SCW'(STUCK_CYCLES - 1)) begin
                    state_n = ST_FAULT;
                    dcnt_n  = '0;
                end else begin
                    scnt_n = scnt + SCW'(1);
                end
            end
            // Stuck time keeps accumulating across short releases.
            ST_HOLD: begin
                if (s) begin
                    state_n = ST_PRESENT;
                    hcnt_n  = '0;
                end else if (hcnt == HCW'(HOLD_CYCLES)) begin
                    state_n = ST_IDLE;
                end else begin
                    hcnt_n = hcnt + HCW'(1);
                end
            end
            ST_FAULT: begin
                if (s) begin
                    dcnt_n = '0;
                end else if (dcnt == DCW'(DEB_CYCLES - 1)) begin
                    state_n = ST_IDLE;
                end else begin
                    dcnt_n = dcnt + DCW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

`ifdef CAR_COUNT_EN
    // Saturating count of debounced detections; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (count_clr) begin
            count <= '0;
        end else if ((state == ST_ARM) && (state_n == ST_PRESENT) && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/car_sensor_conditioner.sv
// Two-lane loop-sensor conditioner feeding the traffic-light controller's carA/carB inputs.
// Per-lane car counters (count_clr/countA/countB) are present only when CAR_COUNT_EN is defined.
module car_sensor_conditioner
    import car_sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int unsigned STUCK_CYCLES = DEF_STUCK_CYCLES
`ifdef CAR_COUNT_EN
    ,
    parameter int unsigned CNT_W        = DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensA_raw,
    input  logic             sensB_raw,
    output logic             carA,
    output logic             carB,
    output logic             faultA,
    output logic             faultB
`ifdef CAR_COUNT_EN
    ,
    input  logic             count_clr,
    output logic [CNT_W-1:0] countA,
    output logic [CNT_W-1:0] countB
`endif
);

    car_sensor_channel #(
        .DEB_CYCLES   (DEB_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES)
`ifdef CAR_COUNT_EN
        ,
        .CNT_W        (CNT_W)
`endif
    ) u_lane_a (
        .clk       (clk),
        .rst       (rst),
        .raw       (sensA_raw),
        .car       (carA),
        .fault     (faultA)
`ifdef CAR_COUNT_EN
        ,
        .count_clr (count_clr),
        .count     (countA)
`endif
    );

    car_sensor_channel #(
        .DEB_CYCLES   (DEB_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES)
`ifdef CAR_COUNT_EN
        ,
        .CNT_W        (CNT_W)
`endif
    ) u_lane_b (
        .clk       (clk),
        .rst       (rst),
        .raw       (sensB_raw),
        .car       (carB),
        .fault     (faultB)
`ifdef CAR_COUNT_EN
        ,
        .count_clr (count_clr),
        .count     (countB)
`endif
    );

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Self-checking bench for car_sensor_conditioner; counter checks run when CAR_COUNT_EN is defined.
module tb_car_sensor_conditioner;

    typedef struct {
        string name;
        logic  a;
        logic  b;
        int    n;
        logic  ca;
        logic  cb;
        logic  fa;
        logic  fb;
        logic  every;
    } vec_t;

    typedef struct {
        string name;
        logic  ca;
        logic  cb;
        logic  fa;
        logic  fb;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic sensA_raw, sensB_raw;
    logic carA, carB, faultA, faultB;
`ifdef CAR_COUNT_EN
    localparam int unsigned TB_CNT_W = 2;
    logic                count_clr;
    logic [TB_CNT_W-1:0] countA, countB;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

`ifdef CAR_COUNT_EN
    car_sensor_conditioner #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sensA_raw (sensA_raw),
        .sensB_raw (sensB_raw),
        .carA      (carA),
        .carB      (carB),
        .faultA    (faultA),
        .faultB    (faultB),
        .count_clr (count_clr),
        .countA    (countA),
        .countB    (countB)
    );
`else
    car_sensor_conditioner dut (
        .clk       (clk),
        .rst       (rst),
        .sensA_raw (sensA_raw),
        .sensB_raw (sensB_raw),
        .carA      (carA),
        .carB      (carB),
        .faultA    (faultA),
        .faultB    (faultB)
    );
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string name, input logic a, input logic b, input int n,
                                input logic ca, input logic cb, input logic fa, input logic fb,
                                input logic every);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.n = n;
        v.ca = ca; v.cb = cb; v.fa = fa; v.fb = fb; v.every = every;
        return v;
    endfunction

    // Drive one segment; expectations are queued at each checked edge and scored at the next negedge.
    task automatic run_seg(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            sensA_raw = v.a;
            sensB_raw = v.b;
            @(posedge clk);
            if (v.every || i == v.n - 1)
                sb_q.push_back('{v.name, v.ca, v.cb, v.fa, v.fb});
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, ".carA"},   32'(carA),   32'(mon_e.ca));
            check({mon_e.name, ".carB"},   32'(carB),   32'(mon_e.cb));
            check({mon_e.name, ".faultA"}, 32'(faultA), 32'(mon_e.fa));
            check({mon_e.name, ".faultB"}, 32'(faultB), 32'(mon_e.fb));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Short pulse rejected
        vecs.push_back(mk("t1_short_hi", 1, 0, 3,   0, 0, 0, 0, 1));
        vecs.push_back(mk("t1_after",    0, 0, 6,   0, 0, 0, 0, 1));
        // Assert after 6 edges, release 11 edges after raw drops
        vecs.push_back(mk("t2_deb",      1, 0, 5,   0, 0, 0, 0, 1));
        vecs.push_back(mk("t2_rise",     1, 0, 1,   1, 0, 0, 0, 0));
        vecs.push_back(mk("t2_on",       1, 0, 4,   1, 0, 0, 0, 1));
        vecs.push_back(mk("t2_hold",     0, 0, 10,  1, 0, 0, 0, 1));
        vecs.push_back(mk("t2_fall",     0, 0, 1,   0, 0, 0, 0, 0));
        vecs.push_back(mk("t2_idle",     0, 0, 4,   0, 0, 0, 0, 1));
        // Low glitches of 3 and 8 cycles bridged, no dip
        vecs.push_back(mk("t3_deb",      1, 0, 5,   0, 0, 0, 0, 1));
        vecs.push_back(mk("t3_rise",     1, 0, 1,   1, 0, 0, 0, 0));
        vecs.push_back(mk("t3_glitch3",  0, 0, 3,   1, 0, 0, 0, 1));
        vecs.push_back(mk("t3_back",     1, 0, 4,   1, 0, 0, 0, 1));
        vecs.push_back(mk("t3_glitch8",  0, 0, 8,   1, 0, 0, 0, 1));
        vecs.push_back(mk("t3_back8",    1, 0, 6,   1, 0, 0, 0, 1));
        vecs.push_back(mk("t3_hold",     0, 0, 10,  1, 0, 0, 0, 1));
        vecs.push_back(mk("t3_fall",     0, 0, 1,   0, 0, 0, 0, 0));
        vecs.push_back(mk("t3_idle",     0, 0, 4,   0, 0, 0, 0, 1));
        // Lane B stuck on, with an independent lane A car inside the present window
        vecs.push_back(mk("t4_deb",      0, 1, 5,   0, 0, 0, 0, 1));
        vecs.push_back(mk("t4_rise",     0, 1, 1,   0, 1, 0, 0, 0));
        vecs.push_back(mk("t4_p1",       0, 1, 100, 0, 1, 0, 0, 1));
        vecs.push_back(mk("t4_a_deb",    1, 1, 5,   0, 1, 0, 0, 1));
        vecs.push_back(mk("t4_a_rise",   1, 1, 1,   1, 1, 0, 0, 0));
        vecs.push_back(mk("t4_a_on",     1, 1, 4,   1, 1, 0, 0, 1));
        vecs.push_back(mk("t4_a_hold",   0, 1, 10,  1, 1, 0, 0, 1));
        vecs.push_back(mk("t4_a_fall",   0, 1, 1,   0, 1, 0, 0, 0));
        vecs.push_back(mk("t4_p2",       0, 1, 133, 0, 1, 0, 0, 1));
        vecs.push_back(mk("t4_fault",    0, 1, 1,   0, 0, 0, 1, 0));
        vecs.push_back(mk("t4_stuck",    0, 1, 39,  0, 0, 0, 1, 1));
        vecs.push_back(mk("t4_rel",      0, 0, 5,   0, 0, 0, 1, 1));
        vecs.push_back(mk("t4_clear",    0, 0, 1,   0, 0, 0, 0, 0));
        vecs.push_back(mk("t4_idle",     0, 0, 3,   0, 0, 0, 0, 1));

        rst = 1'b1;
        sensA_raw = 1'b0;
        sensB_raw = 1'b0;
`ifdef CAR_COUNT_EN
        count_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset.carA",   32'(carA),   32'd0);
        check("reset.carB",   32'(carB),   32'd0);
        check("reset.faultA", 32'(faultA), 32'd0);
        check("reset.faultB", 32'(faultB), 32'd0);
`ifdef CAR_COUNT_EN
        check("reset.countA", 32'(countA), 32'd0);
        check("reset.countB", 32'(countB), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_seg(vecs[i]);
        drain();

        // Asynchronous reset while a car is present, then full re-detection
        run_seg(mk("t5_deb",  1, 0, 5, 0, 0, 0, 0, 1));
        run_seg(mk("t5_rise", 1, 0, 1, 1, 0, 0, 0, 0));
        drain();
        rst = 1'b1;
        #1;
        check("t5_async.carA", 32'(carA), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run_seg(mk("t5_redeb",  1, 0, 5,  0, 0, 0, 0, 1));
        run_seg(mk("t5_rerise", 1, 0, 1,  1, 0, 0, 0, 0));
        run_seg(mk("t5_hold",   0, 0, 10, 1, 0, 0, 0, 1));
        run_seg(mk("t5_fall",   0, 0, 1,  0, 0, 0, 0, 0));
        run_seg(mk("t5_idle",   0, 0, 2,  0, 0, 0, 0, 1));
        drain();

`ifdef CAR_COUNT_EN
        count_clr = 1'b1;
        run_seg(mk("t6_clr", 0, 0, 1, 0, 0, 0, 0, 0));
        count_clr = 1'b0;
        check("t6_clr.countA", 32'(countA), 32'd0);
        check("t6_clr.countB", 32'(countB), 32'd0);
        for (int k = 0; k < 3; k++) begin
            run_seg(mk("t6_on",  1, 0, 10, 1, 0, 0, 0, 0));
            run_seg(mk("t6_off", 0, 0, 12, 0, 0, 0, 0, 0));
            check("t6_count.countA", 32'(countA), 32'(k + 1));
        end
        check("t6_count.countB", 32'(countB), 32'd0);
        run_seg(mk("t6_deb4", 1, 0, 5, 0, 0, 0, 0, 1));
        count_clr = 1'b1;
        run_seg(mk("t6_det4", 1, 0, 1, 1, 0, 0, 0, 0));
        count_clr = 1'b0;
        check("t6_clr_wins.countA", 32'(countA), 32'd0);
        run_seg(mk("t6_on4",  1, 0, 4,  1, 0, 0, 0, 1));
        run_seg(mk("t6_off4", 0, 0, 12, 0, 0, 0, 0, 0));
        check("t6_after_clr.countA", 32'(countA), 32'd0);
        for (int k = 0; k < 4; k++) begin
            run_seg(mk("t6_son",  1, 0, 10, 1, 0, 0, 0, 0));
            run_seg(mk("t6_soff", 0, 0, 12, 0, 0, 0, 0, 0));
        end
        check("t6_sat.countA", 32'(countA), 32'd3);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
